// File: rtl/sine_table_reader.sv
// ---------------------------------------------------------------------------
// sine_table_reader
//
// Purpose:
//    DDS-style read-side player for a preloaded single-port sine RAM.
//    A phase accumulator steps by a frequency tuning word. Its top bits
//    address the RAM. Read data is captured into a small 2-entry buffer
//    and streamed out on a valid/ready interface. This block never writes
//    the RAM.
//
// Configuration:
//    SINE_QUARTER_EN  (undefined by default)
//       Undefined : the RAM holds a full wave. The address is the top AW
//                   bits of the phase.
//       Defined   : the RAM holds a rising quarter wave in offset-binary.
//                   The top two phase bits select the quadrant. Odd
//                   quadrants mirror the address and the second half-wave
//                   inverts the sample.
//
// Parameters:
//    AW  RAM address width
//    DW  sample / RAM data width (offset-binary)
//    PW  phase accumulator width, must satisfy PW >= AW+2
//    CW  accepted-sample counter width
//
// Ports:
//    clk         system clock, rising edge
//    rst         asynchronous, active-high reset
//    start       pulse: load ftw, clear phase and counter, enter RUN
//    stop        pulse: stop issuing reads, drain, then return to IDLE
//    ftw         frequency tuning word, sampled only when start is high
//    mem_addr    registered RAM address
//    mem_we      RAM write enable, always 0
//    mem_din     RAM write data, always 0
//    mem_qout    RAM read data, sampled one clock after mem_addr is issued
//    m_valid     output sample valid (buffer not empty)
//    m_ready     downstream ready
//    m_data      output sample (buffer head)
//    busy        high while in RUN or DRAIN
//    sample_cnt  samples accepted since the last start, wraps modulo 2^CW
// ---------------------------------------------------------------------------
module sine_table_reader #(
   parameter int AW = 8,
   parameter int DW = 8,
   parameter int PW = 16,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic [PW-1:0] ftw,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_qout,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic          busy,
   output logic [CW-1:0] sample_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;

   logic [PW-1:0]   phase;
   logic [PW-1:0]   ftw_reg;
   logic [PW-1:0]   phase_base;
   logic [PW-1:0]   phase_step;
   logic [AW-1:0]   issue_addr;

   logic            inflight;
   logic            inflight_next;
   logic            issue;
   logic            capture;
   logic            pop;
   logic [DW-1:0]   cap_data;

   logic [DW-1:0]   fifo0;
   logic [DW-1:0]   fifo1;
   logic            rd_ptr;
   logic            wr_ptr;
   logic [1:0]      count;
   logic [1:0]      count_next;
   logic [2:0]      pending;

   // The RAM is read-only from this side.
   assign mem_we  = 1'b0;
   assign mem_din = '0;

   // Handshake side of the buffer.
   assign m_valid = (count != 2'd0);
   assign m_data  = rd_ptr ? fifo1 : fifo0;
   assign pop     = m_valid & m_ready;

   // A start flushes the read that is still in flight, so that result is
   // never captured.
   assign capture = inflight & ~start;

   // Buffer entries, plus the read in flight, minus this cycle's pop.
   // Counting the pop keeps a sample flowing every cycle while ready is
   // high. It also guarantees the next capture still finds a free slot,
   // even if ready drops right after the issue.
   assign pending = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

   // On start the first read uses phase 0 and the freshly presented ftw.
   // Otherwise the read uses the running phase and the latched ftw.
   assign phase_base = start ? '0  : phase;
   assign phase_step = start ? ftw : ftw_reg;

   assign count_next    = start ? 2'd0 : (count + {1'b0, capture} - {1'b0, pop});
   assign inflight_next = issue;

`ifdef SINE_QUARTER_EN
   logic [1:0]    quad;
   logic [AW-1:0] idx;
   logic          quad_hi_d;

   // Odd quadrants walk the quarter table backwards.
   assign quad       = phase_base[PW-1:PW-2];
   assign idx        = phase_base[PW-3 -: AW];
   assign issue_addr = quad[0] ? ~idx : idx;

   // The half-wave bit travels alongside the read. The data it belongs to
   // arrives one cycle after the address is issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quad_hi_d <= 1'b0;
      end else if (issue) begin
         quad_hi_d <= quad[1];
      end
   end

   // The second half-wave is the first half inverted about the midpoint.
   // In offset-binary this is a plain bitwise inversion.
   assign cap_data = quad_hi_d ? ~mem_qout : mem_qout;
`else
   assign issue_addr = phase_base[PW-1 -: AW];
   assign cap_data   = mem_qout;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. Start re-arms from any state and overrides stop.
   // DRAIN exits when the buffer and read pipe will both be empty after
   // this edge. busy therefore falls right after the last accept.
   always_comb begin
      state_next = state;
      if (start) begin
         state_next = RUN;
      end else begin
         case (state)
            IDLE:    state_next = IDLE;
            RUN:     if (stop) state_next = DRAIN;
            DRAIN:   if ((count_next == 2'd0) && !inflight_next) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Output / control decode. Reads are only issued in RUN while a stop is
   // not being requested and there is room for the result. A start always
   // issues the first read of the new stream.
   always_comb begin
      busy  = 1'b0;
      issue = 1'b0;
      case (state)
         RUN: begin
            busy  = 1'b1;
            issue = !stop && (pending < 3'd2);
         end
         DRAIN: begin
            busy  = 1'b1;
         end
         default: begin
            busy  = 1'b0;
         end
      endcase
      if (start) begin
         issue = 1'b1;
      end
   end

   // Phase accumulator and RAM address register. The phase only advances
   // when a read is issued, so back-pressure never skips a table entry.
   // The accumulator wraps silently modulo 2^PW.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase    <= '0;
         ftw_reg  <= '0;
         mem_addr <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= inflight_next;
         if (start) begin
            ftw_reg <= ftw;
         end
         if (issue) begin
            mem_addr <= issue_addr;
            phase    <= phase_base + phase_step;
         end
      end
   end

   // Two-entry sample buffer. A capture and a pop in the same cycle leave
   // the occupancy unchanged. A start discards everything buffered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo0  <= '0;
         fifo1  <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (start) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (capture) begin
            if (wr_ptr) begin
               fifo1 <= cap_data;
            end else begin
               fifo0 <= cap_data;
            end
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count_next;
      end
   end

   // Accepted-sample counter. It counts in every state and restarts on start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_cnt <= '0;
      end else if (start) begin
         sample_cnt <= '0;
      end else if (pop) begin
         sample_cnt <= sample_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_sine_table_reader.sv
// ---------------------------------------------------------------------------
// tb_sine_table_reader
//
// Directed bench for sine_table_reader with AW=8, DW=8, PW=16, CW=16.
// The bench RAM holds mem[a] = a. It is read asynchronously from the
// registered mem_addr, so data for an issued address is present for the
// capture edge one clock later.
// Inputs change and outputs are checked 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_sine_table_reader;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int PW = 16;
   localparam int CW = 16;

   logic          clk     = 1'b0;
   logic          rst     = 1'b1;
   logic          start   = 1'b0;
   logic          stop    = 1'b0;
   logic          m_ready = 1'b0;
   logic [PW-1:0] ftw     = '0;

   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_qout;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          busy;
   logic [CW-1:0] sample_cnt;

   logic [DW-1:0] ram [256];

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] exp_b [5] = '{8'h00, 8'h02, 8'h05, 8'h07, 8'h0A};
   logic [7:0] exp_c [4] = '{8'h00, 8'h80, 8'h00, 8'h80};
   logic [7:0] exp_qa [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
   logic [7:0] exp_qd [4] = '{8'h00, 8'hFF, 8'hFF, 8'h00};

   always #5 clk = ~clk;

   assign mem_qout = ram[mem_addr];

   sine_table_reader #(
      .AW(AW), .DW(DW), .PW(PW), .CW(CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .ftw        (ftw),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_din    (mem_din),
      .mem_qout   (mem_qout),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .busy       (busy),
      .sample_cnt (sample_cnt)
   );

   // Single comparison point: counts every vector and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic p, input logic [PW-1:0] f, input logic r);
      start   = s;
      stop    = p;
      ftw     = f;
      m_ready = r;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i] = i[7:0];
      end
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      tick;
      tick;

      // Reset state.
      checkOutput("rst_valid",  m_valid,    0);
      checkOutput("rst_busy",   busy,       0);
      checkOutput("rst_cnt",    sample_cnt, 0);
      checkOutput("rst_addr",   mem_addr,   0);
      checkOutput("rst_data",   m_data,     0);
      checkOutput("rst_we",     mem_we,     0);
      checkOutput("rst_din",    mem_din,    0);
      rst = 1'b0;
      tick;

`ifndef SINE_QUARTER_EN
      // ftw=0x0100, ready high: 0,1,2,... gap-free, first valid two cycles after start.
      applyStimulus(1'b1, 1'b0, 16'h0100, 1'b1);
      checkOutput("a_c0_valid", m_valid, 0);
      tick;
      applyStimulus(1'b0, 1'b0, 16'h0100, 1'b1);
      checkOutput("a_c1_addr",  mem_addr, 0);
      checkOutput("a_c1_valid", m_valid,  0);
      checkOutput("a_c1_busy",  busy,     1);
      tick;
      for (int i = 0; i < 8; i++) begin
         checkOutput("a_valid", m_valid,    1);
         checkOutput("a_data",  m_data,     i);
         checkOutput("a_cnt",   sample_cnt, i);
         tick;
      end

      // Re-arm in RUN with ftw=0x0280.
      applyStimulus(1'b1, 1'b0, 16'h0280, 1'b1);
      tick;
      applyStimulus(1'b0, 1'b0, 16'h0280, 1'b1);
      checkOutput("b_flush_valid", m_valid,    0);
      checkOutput("b_flush_cnt",   sample_cnt, 0);
      checkOutput("b_addr0",       mem_addr,   0);
      tick;
      for (int i = 0; i < 5; i++) begin
         checkOutput("b_valid", m_valid, 1);
         checkOutput("b_data",  m_data,  exp_b[i]);
         tick;
      end

      // ftw=0x8000: the phase wraps, alternating 0x00 / 0x80.
      applyStimulus(1'b1, 1'b0, 16'h8000, 1'b1);
      tick;
      applyStimulus(1'b0, 1'b0, 16'h8000, 1'b1);
      tick;
      for (int i = 0; i < 4; i++) begin
         checkOutput("c_valid", m_valid, 1);
         checkOutput("c_data",  m_data,  exp_c[i]);
         tick;
      end

      // Back-pressure: ready low for 5 cycles while sample 2 is at the head.
      applyStimulus(1'b1, 1'b0, 16'h0100, 1'b1);
      tick;
      applyStimulus(1'b0, 1'b0, 16'h0100, 1'b1);
      tick;
      for (int i = 0; i < 2; i++) begin
         checkOutput("d_pre_data", m_data, i);
         tick;
      end
      applyStimulus(1'b0, 1'b0, 16'h0100, 1'b0);
      checkOutput("d_drop_data", m_data,     2);
      checkOutput("d_drop_cnt",  sample_cnt, 2);
      for (int i = 0; i < 5; i++) begin
         tick;
         checkOutput("d_hold_valid", m_valid,    1);
         checkOutput("d_hold_data",  m_data,     2);
         checkOutput("d_hold_cnt",   sample_cnt, 2);
         checkOutput("d_hold_addr",  mem_addr,   3);
      end
      applyStimulus(1'b0, 1'b0, 16'h0100, 1'b1);
      for (int k = 2; k < 8; k++) begin
         checkOutput("d_resume_valid", m_valid,    1);
         checkOutput("d_resume_data",  m_data,     k);
         checkOutput("d_resume_cnt",   sample_cnt, k);
         tick;
      end

      // Stop with ready low while one sample is buffered and one is in flight.
      applyStimulus(1'b1, 1'b0, 16'h0100, 1'b0);
      tick;
      applyStimulus(1'b0, 1'b0, 16'h0100, 1'b0);
      tick;
      checkOutput("e_c2_addr", mem_addr, 1);
      applyStimulus(1'b0, 1'b1, 16'h0100, 1'b0);
      tick;
      applyStimulus(1'b0, 1'b0, 16'h0100, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("e_drain_addr",  mem_addr, 1);
         checkOutput("e_drain_busy",  busy,     1);
         checkOutput("e_drain_valid", m_valid,  1);
         checkOutput("e_drain_data",  m_data,   0);
         tick;
      end
      applyStimulus(1'b0, 1'b0, 16'h0100, 1'b1);
      checkOutput("e_out0", m_data, 0);
      tick;
      checkOutput("e_out1_valid", m_valid, 1);
      checkOutput("e_out1",       m_data,  1);
      checkOutput("e_out1_busy",  busy,    1);
      tick;
      checkOutput("e_end_valid", m_valid,    0);
      checkOutput("e_end_busy",  busy,       0);
      checkOutput("e_end_cnt",   sample_cnt, 2);
      tick;
      checkOutput("e_idle_valid", m_valid,  0);
      checkOutput("e_idle_addr",  mem_addr, 1);
`else
      // Quarter-wave table: ftw=0x4000 visits one point per quadrant.
      applyStimulus(1'b1, 1'b0, 16'h4000, 1'b1);
      tick;
      applyStimulus(1'b0, 1'b0, 16'h4000, 1'b1);
      checkOutput("q_addr", mem_addr, exp_qa[0]);
      tick;
      for (int i = 0; i < 4; i++) begin
         checkOutput("q_valid", m_valid, 1);
         checkOutput("q_data",  m_data,  exp_qd[i]);
         if (i < 3) begin
            checkOutput("q_addr", mem_addr, exp_qa[i+1]);
         end
         tick;
      end
`endif

      // Async reset mid-RUN, then a fresh start from address 0.
      applyStimulus(1'b1, 1'b0, 16'h0100, 1'b1);
      tick;
      applyStimulus(1'b0, 1'b0, 16'h0100, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick;
      end
      checkOutput("f_pre_busy", busy, 1);
      rst = 1'b1;
      #1;
      checkOutput("f_rst_valid", m_valid,    0);
      checkOutput("f_rst_busy",  busy,       0);
      checkOutput("f_rst_cnt",   sample_cnt, 0);
      checkOutput("f_rst_addr",  mem_addr,   0);
      tick;
      rst = 1'b0;
      tick;
      applyStimulus(1'b1, 1'b0, 16'h0100, 1'b1);
      tick;
      applyStimulus(1'b0, 1'b0, 16'h0100, 1'b1);
      checkOutput("f_restart_addr", mem_addr, 0);
      tick;
      checkOutput("f_restart_valid", m_valid, 1);
      checkOutput("f_restart_data",  m_data,  0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sine_table_reader.md
Name:
sine_table_reader

Overview:
- Read-side companion to the single-port sine RAM (SpRamRfSine): a DDS-style player that steps a phase accumulator and drives the RAM address port.
- Captures the RAM's 1-cycle-latency read data and streams samples out on a valid/ready interface.
- Sits between the preloaded sine table and any downstream sample consumer (DAC model, filter, scope capture).

Parameters:
- AW, 8, RAM address width.
- DW, 8, sample/data width (offset-binary samples).
- PW, 16, phase accumulator width; PW >= AW+2.
- CW, 16, accepted-sample counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  pulse: load ftw, clear phase, enter RUN.
- stop  input  1  pulse: stop issuing reads, drain, return to IDLE.
- ftw  input  PW  frequency tuning word, sampled on start only.
- mem_addr  output  AW  RAM address, registered.
- mem_we  output  1  RAM write enable, tied 0.
- mem_din  output  DW  RAM write data, tied 0.
- mem_qout  input  DW  RAM read data, valid 1 cycle after mem_addr.
- m_valid  output  1  sample valid.
- m_ready  input  1  downstream ready.
- m_data  output  DW  sample.
- busy  output  1  high in RUN or DRAIN.
- sample_cnt  output  CW  samples accepted (valid&&ready) since last start; wraps modulo 2^CW.

Behaviour:
- Reset values: all outputs 0; phase 0; FSM IDLE; buffer empty; no read in flight.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start.
  - RUN -> DRAIN on stop.
  - DRAIN -> IDLE when no read is in flight and the buffer is empty.
  - start in RUN or DRAIN re-arms: flushes buffer and in-flight read, reloads ftw, phase=0, sample_cnt=0, state=RUN.
  - start and stop in the same cycle: start wins.
- Read issue: in RUN, a read is issued when (buffer entries + in-flight) < 2.
  - On issue: mem_addr <= phase[PW-1 -: AW]; phase <= phase + ftw, modulo 2^PW (wraps silently).
  - First issue is in the cycle after start, with phase 0.
- Read data: mem_qout is captured into a 2-entry FIFO the cycle after issue.
  - Latency: start at cycle 0 -> mem_addr valid at cycle 1 -> m_valid at cycle 2.
- Output handshake:
  - m_valid = buffer not empty; m_data = buffer head.
  - m_data must hold stable while m_valid && !m_ready.
  - No sample is dropped or duplicated under any m_ready pattern.
  - With m_ready held high: one sample per cycle, gap-free.
- Capture and pop may occur in the same cycle; occupancy is unchanged.
- DRAIN: no new reads; the in-flight read is still captured; the buffer empties through the handshake.
- sample_cnt increments on each accepted sample, in every state.
- Async reset mid-operation: immediate return to reset values; the in-flight read result is discarded.
- ftw=0: repeats a single address (DC output); legal.

Optional Feature:
- Macro: SINE_QUARTER_EN.
- Defined: the table holds a quarter wave (offset-binary, rising from the midpoint toward max).
  - quadrant q = phase[PW-1:PW-2]; idx = phase[PW-3 -: AW].
  - mem_addr = q[0] ? ~idx : idx.
  - q[1] is delayed 1 cycle to align with the read data.
  - Captured sample = q[1] ? ~mem_qout : mem_qout.
- Undefined: the table holds a full wave, direct addressing as above; no quadrant logic is present.

Test Plan:
- Bench RAM preloaded mem[a]=a; ftw=16'h0100, start, m_ready=1 -> m_data 0x00,0x01,0x02,... each cycle, first m_valid 2 cycles after start.
- ftw=16'h0280 -> m_data 0x00,0x02,0x05,0x07,0x0A; ftw=16'h8000 -> 0x00,0x80,0x00,0x80 (wrap).
- ftw=16'h0100, m_ready low for 5 cycles mid-stream -> m_data held stable; sequence resumes with no gaps or duplicates; sample_cnt matches the accepted count.
- stop while m_ready=0 with buffer full -> no new mem_addr changes; exactly the buffered/in-flight samples delivered after ready returns; busy falls after the last accept.
- rst asserted mid-RUN -> m_valid, busy, sample_cnt, mem_addr all 0 immediately; a new start restarts at address 0.
- SINE_QUARTER_EN, AW=8, PW=16, ftw=16'h4000 -> addresses 0x00,0xFF,0x00,0xFF; m_data = mem, mem, ~mem, ~mem.
